// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the two-requester BRAM port arbiter.
package bram_port_arbiter_pkg;
  localparam logic REQ0     = 1'b0;
  localparam logic REQ1     = 1'b1;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // One-hot grant for a two-way request; prio breaks the tie.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] g;
    g = req;
    if (req == 2'b11) g = prio ? 2'b10 : 2'b01;
    return g;
  endfunction
endpackage

// File: rtl/bram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority flips on contention.
module rr_arbiter2
  import bram_port_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic prio;

  always_comb begin
    grant = 2'b00;
    if (!reset) grant = rr_pick(req, prio);
  end

  // Uncontended grants leave the priority alone so a lone requester cannot starve the other.
  always_ff @(posedge clock) begin
    if (reset)              prio <= REQ0;
    else if (req == 2'b11)  prio <= ~prio;
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one 1R1W BRAM between two valid/ready requesters with independent read/write arbitration.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0] req0_writeData,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0] req1_writeData,
  output logic                  req1_ready,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_readData,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_readData,
  output logic                  bram_readEnable,
  output logic [ADDR_WIDTH-1:0] bram_readAddress,
  output logic                  bram_writeEnable,
  output logic [ADDR_WIDTH-1:0] bram_writeAddress,
  output logic [DATA_WIDTH-1:0] bram_writeData,
  input  logic [DATA_WIDTH-1:0] bram_readData
);
  logic [1:0] rd_req, wr_req, rd_gnt, wr_gnt;
  logic       rd_pending, rd_owner, resp_live;

  assign rd_req = {req1_valid & (req1_write == OP_READ),  req0_valid & (req0_write == OP_READ)};
  assign wr_req = {req1_valid & (req1_write == OP_WRITE), req0_valid & (req0_write == OP_WRITE)};

  rr_arbiter2 u_rd_arb (.clock(clock), .reset(reset), .req(rd_req), .grant(rd_gnt));
  rr_arbiter2 u_wr_arb (.clock(clock), .reset(reset), .req(wr_req), .grant(wr_gnt));

  assign req0_ready = rd_gnt[0] | wr_gnt[0];
  assign req1_ready = rd_gnt[1] | wr_gnt[1];

  always_comb begin
    bram_readEnable   = |rd_gnt;
    bram_readAddress  = '0;
    bram_writeEnable  = |wr_gnt;
    bram_writeAddress = '0;
    bram_writeData    = '0;
    if (rd_gnt[0])      bram_readAddress = req0_address;
    else if (rd_gnt[1]) bram_readAddress = req1_address;
    if (wr_gnt[0]) begin
      bram_writeAddress = req0_address;
      bram_writeData    = req0_writeData;
    end else if (wr_gnt[1]) begin
      bram_writeAddress = req1_address;
      bram_writeData    = req1_writeData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_owner   <= REQ0;
    end else begin
      rd_pending <= |rd_gnt;
      if (|rd_gnt) rd_owner <= rd_gnt[1];
    end
  end

  // Reset in the return cycle drops an in-flight response.
  assign resp_live      = rd_pending & ~reset;
  assign resp0_valid    = resp_live & (rd_owner == REQ0);
  assign resp1_valid    = resp_live & (rd_owner == REQ1);
  assign resp0_readData = resp0_valid ? bram_readData : '0;
  assign resp1_readData = resp1_valid ? bram_readData : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed + random bench for bram_port_arbiter against a transaction-level reference model.
module tb_bram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_write, req1_valid, req1_write;
  logic [AW-1:0] req0_address, req1_address;
  logic [DW-1:0] req0_writeData, req1_writeData;
  logic          req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_readData, resp1_readData;
  logic          bram_readEnable, bram_writeEnable;
  logic [AW-1:0] bram_readAddress, bram_writeAddress;
  logic [DW-1:0] bram_writeData, bram_readData;

  always #5 clk = ~clk;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
    .req0_writeData(req0_writeData), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
    .req1_writeData(req1_writeData), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_readData(resp0_readData),
    .resp1_valid(resp1_valid), .resp1_readData(resp1_readData),
    .bram_readEnable(bram_readEnable), .bram_readAddress(bram_readAddress),
    .bram_writeEnable(bram_writeEnable), .bram_writeAddress(bram_writeAddress),
    .bram_writeData(bram_writeData), .bram_readData(bram_readData)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return (32'h0101_0101 * a) ^ 32'hA5A5_A5A5;
  endfunction

  // BRAM model: registered read, write-first on same-address collision.
  logic          init_mem;
  logic [DW-1:0] bram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < (1<<AW); i++) bram_mem[i] <= init_val(i);
    end else begin
      if (bram_writeEnable) bram_mem[bram_writeAddress] <= bram_writeData;
      if (bram_readEnable)
        bram_readData <= (bram_writeEnable && bram_writeAddress == bram_readAddress) ?
                         bram_writeData : bram_mem[bram_readAddress];
    end
  end

  // Reference model state: memory image, per-port priority, expected response per requester.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          prio_rd, prio_wr;
  logic [1:0]    cur_rv;
  logic [DW-1:0] cur_rd [0:1];
  logic [1:0]    acc, last_rdy;
  logic          last_r1v;
  logic [DW-1:0] last_r1d;
  int            n_resp0;
  int            n_assert = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic n);
    return n ? req1_address : req0_address;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic n);
    return n ? req1_writeData : req0_writeData;
  endfunction

  // One clock: check everything visible this cycle, then advance the model.
  task automatic cycle();
    logic [1:0] rq, wq, exp_rdy, nxt_rv;
    logic       rwin, wwin, rv0, rv1;
    @(negedge clk);
    rq = reset ? 2'b00 : {req1_valid & ~req1_write, req0_valid & ~req0_write};
    wq = reset ? 2'b00 : {req1_valid &  req1_write, req0_valid &  req0_write};
    rwin = (rq == 2'b11) ? prio_rd : rq[1];
    wwin = (wq == 2'b11) ? prio_wr : wq[1];
    exp_rdy = 2'b00;
    if (rq != 2'b00) exp_rdy[rwin] = 1'b1;
    if (wq != 2'b00) exp_rdy[wwin] = 1'b1;
    rv0 = cur_rv[0] & ~reset;
    rv1 = cur_rv[1] & ~reset;
    chk("ready0", req0_ready, exp_rdy[0]);
    chk("ready1", req1_ready, exp_rdy[1]);
    chk("rd_en", bram_readEnable, |rq);
    chk("rd_addr", bram_readAddress, (rq != 2'b00) ? addr_of(rwin) : '0);
    chk("wr_en", bram_writeEnable, |wq);
    chk("wr_addr", bram_writeAddress, (wq != 2'b00) ? addr_of(wwin) : '0);
    chk("wr_data", bram_writeData, (wq != 2'b00) ? data_of(wwin) : '0);
    chk("resp0_valid", resp0_valid, rv0);
    chk("resp0_data", resp0_readData, rv0 ? cur_rd[0] : '0);
    chk("resp1_valid", resp1_valid, rv1);
    chk("resp1_data", resp1_readData, rv1 ? cur_rd[1] : '0);
    last_rdy = {req1_ready, req0_ready};
    last_r1v = resp1_valid;
    last_r1d = resp1_readData;
    if (resp0_valid) n_resp0++;
    acc = exp_rdy;
    if (wq != 2'b00) ref_mem[addr_of(wwin)] = data_of(wwin);
    nxt_rv = 2'b00;
    if (rq != 2'b00) begin
      nxt_rv[rwin] = 1'b1;
      cur_rd[rwin] = ref_mem[addr_of(rwin)];
    end
    if (rq == 2'b11) prio_rd = ~prio_rd;
    if (wq == 2'b11) prio_wr = ~prio_wr;
    if (reset) begin
      prio_rd = 1'b0;
      prio_wr = 1'b0;
    end
    cur_rv = nxt_rv;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cycle();
    if (acc[0]) req0_valid = 1'b0;
    if (acc[1]) req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (!req0_valid && !req1_valid) break;
      step();
    end
    chk("drain_idle", {req1_valid, req0_valid}, 2'b00);
  endtask

  task automatic set_req(input logic n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n) begin
      req1_valid = 1'b1; req1_write = w; req1_address = a; req1_writeData = d;
    end else begin
      req0_valid = 1'b1; req0_write = w; req0_address = a; req0_writeData = d;
    end
  endtask

  initial begin
    reset = 1'b1; init_mem = 1'b1;
    req0_valid = 0; req0_write = 0; req0_address = 0; req0_writeData = 0;
    req1_valid = 0; req1_write = 0; req1_address = 0; req1_writeData = 0;
    prio_rd = 0; prio_wr = 0; cur_rv = 0; cur_rd[0] = 0; cur_rd[1] = 0;
    acc = 0; last_rdy = 0; last_r1v = 0; last_r1d = 0; n_resp0 = 0;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);

    // Reset held with both requesters contending, then req0 wins first.
    set_req(1'b0, 1'b0, 8'h03, '0);
    set_req(1'b1, 1'b0, 8'h04, '0);
    step();
    init_mem = 1'b0;
    step(); step();
    chk("t1_rdy_in_reset", last_rdy, 2'b00);
    reset = 1'b0;
    step();
    chk("t1_req0_wins", last_rdy, 2'b01);
    drain();
    step();

    // Split ops with write-first forwarding.
    set_req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    set_req(1'b1, 1'b0, 8'h10, '0);
    step();
    chk("t2_both_ready", last_rdy, 2'b11);
    step();
    chk("t2_resp1_valid", last_r1v, 1'b1);
    chk("t2_resp1_data", last_r1d, 32'hDEADBEEF);

    // Read conflict from a fresh priority.
    reset = 1'b1; step(); reset = 1'b0;
    set_req(1'b0, 1'b0, 8'h01, '0);
    set_req(1'b1, 1'b0, 8'h02, '0);
    step();
    chk("t3_first", last_rdy, 2'b01);
    step();
    chk("t3_second", last_rdy, 2'b10);
    step();
    chk("t3_resp1_valid", last_r1v, 1'b1);

    // Write conflict, both keep issuing.
    set_req(1'b0, 1'b1, 8'h20, $urandom);
    set_req(1'b1, 1'b1, 8'h20, $urandom);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t4_alternate", last_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (acc[0]) set_req(1'b0, 1'b1, 8'h20 + 8'(i % 2), $urandom);
      if (acc[1]) set_req(1'b1, 1'b1, 8'h21 - 8'(i % 2), $urandom);
    end
    drain();
    set_req(1'b0, 1'b0, 8'h20, '0); step(); step();
    set_req(1'b0, 1'b0, 8'h21, '0); step(); step();

    // Streaming reads.
    n_resp0 = 0;
    for (int i = 0; i < 16; i++) begin
      set_req(1'b0, 1'b0, 8'(i), '0);
      step();
      chk("t5_stream_ready", last_rdy[0], 1'b1);
    end
    step();
    chk("t5_resp_count", n_resp0, 16);

    // Reset while a read is in flight.
    set_req(1'b1, 1'b0, 8'h05, '0);
    step();
    reset = 1'b1;
    step();
    chk("t6_resp1_suppressed", last_r1v, 1'b0);
    reset = 1'b0;
    step();
    chk("t6_resp1_after", last_r1v, 1'b0);
    set_req(1'b0, 1'b0, 8'h06, '0);
    set_req(1'b1, 1'b0, 8'h07, '0);
    step();
    chk("t6_prio_reset", last_rdy, 2'b01);
    drain();
    step();

    // Random traffic on a small address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid && $urandom_range(0, 3) != 0)
        set_req(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
      if (!req1_valid && $urandom_range(0, 3) != 0)
        set_req(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    drain();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
